// File: rtl/gpu_mem_map_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gpu_mem_map_pkg
// Desc     : Shared-memory map of the double-buffered column region and the
//            state encoding of the column frame writer.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_mem_map_pkg;

  localparam logic [15:0] DIST0_BASE = 16'd63488;
  localparam logic [15:0] TEX0_BASE  = 16'd64000;
  localparam logic [15:0] DIST1_BASE = 16'd64512;
  localparam logic [15:0] TEX1_BASE  = 16'd65024;
  localparam logic [15:0] FLAG_ADDR  = 16'd65535;

  localparam int FLAG_CONSUMED_BIT = 0;
  localparam int FLAG_SEL_BIT      = 1;

  typedef logic [2:0] cfw_state_t;

  localparam cfw_state_t IDLE      = 3'd0;
  localparam cfw_state_t WR_DIST   = 3'd1;
  localparam cfw_state_t WR_TEX    = 3'd2;
  localparam cfw_state_t RD_FLAG   = 3'd3;
  localparam cfw_state_t CHK_FLAG  = 3'd4;
  localparam cfw_state_t POLL_WAIT = 3'd5;
  localparam cfw_state_t WR_FLAG   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter16
// Desc     : 16-bit event counter that sticks at 16'hFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter16 (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_count <= 16'd0;
    end else if (inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/column_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : column_frame_writer
// Desc     : Writes one frame of (distance, texture) column pairs into the
//            back buffer and publishes it through the shared flag word.
// Options  : COLUMN_FRAME_WRITER_PERF_EN adds frames_published and
//            poll_stall_cycles saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module column_frame_writer
  import gpu_mem_map_pkg::*;
#(
  parameter int COLUMNS       = 320,
  parameter int POLL_INTERVAL = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        col_valid,
  output logic        col_ready,
  input  logic [15:0] col_distance,
  input  logic [15:0] col_texture,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic [15:0] mem_rdata,
  output logic        back_sel,
  output logic        frame_done
`ifdef COLUMN_FRAME_WRITER_PERF_EN
  ,
  output logic [15:0] frames_published,
  output logic [15:0] poll_stall_cycles
`endif
);

  localparam int                  c_POLL_W    = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL - 1) : 1;
  localparam logic [8:0]          c_LAST_IDX  = 9'(COLUMNS - 1);
  localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_INTERVAL - 2);

  cfw_state_t          r_state;
  cfw_state_t          w_next;
  logic [8:0]          r_idx;
  logic                r_back_sel;
  logic                r_first_frame;
  logic [15:0]         r_dist;
  logic [15:0]         r_tex;
  logic [c_POLL_W-1:0] r_poll_cnt;
  logic                r_col_ready;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [15:0]         r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic                r_frame_done;

  logic                w_accept;
  logic                w_last;
  logic [15:0]         w_dist_addr;
  logic [15:0]         w_tex_addr;
  logic [15:0]         w_flag_word;
  logic                w_req_n;
  logic                w_we_n;
  logic [15:0]         w_addr_n;
  logic [15:0]         w_wdata_n;
  logic                w_unused_rdata;

  assign w_accept    = col_valid & r_col_ready;
  assign w_last      = (r_idx == c_LAST_IDX);
  assign w_dist_addr = (r_back_sel ? DIST1_BASE : DIST0_BASE) + {7'd0, r_idx};
  assign w_tex_addr  = (r_back_sel ? TEX1_BASE : TEX0_BASE) + {7'd0, r_idx};

  always_comb begin
    w_flag_word               = 16'd0;
    w_flag_word[FLAG_SEL_BIT] = r_back_sel;
  end

  assign w_unused_rdata = ^mem_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_next = WR_DIST;
      WR_DIST:   if (mem_gnt) w_next = WR_TEX;
      WR_TEX: begin
        if (mem_gnt) begin
          if (!w_last)            w_next = IDLE;
          else if (r_first_frame) w_next = WR_FLAG;
          else                    w_next = RD_FLAG;
        end
      end
      RD_FLAG:   if (mem_gnt) w_next = CHK_FLAG;
      CHK_FLAG:  w_next = mem_rdata[FLAG_CONSUMED_BIT] ? WR_FLAG : POLL_WAIT;
      // CHK_FLAG is one of the idle cycles, so the wait runs POLL_INTERVAL-1
      POLL_WAIT: if (r_poll_cnt == c_POLL_LAST) w_next = RD_FLAG;
      WR_FLAG:   if (mem_gnt) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they stay stable
  // for as long as a request is left ungranted.
  always_comb begin
    w_req_n   = 1'b0;
    w_we_n    = 1'b0;
    w_addr_n  = 16'd0;
    w_wdata_n = 16'd0;
    case (w_next)
      WR_DIST: begin
        w_req_n   = 1'b1;
        w_we_n    = 1'b1;
        w_addr_n  = w_dist_addr;
        w_wdata_n = w_accept ? col_distance : r_dist;
      end
      WR_TEX: begin
        w_req_n   = 1'b1;
        w_we_n    = 1'b1;
        w_addr_n  = w_tex_addr;
        w_wdata_n = r_tex;
      end
      RD_FLAG: begin
        w_req_n  = 1'b1;
        w_addr_n = FLAG_ADDR;
      end
      WR_FLAG: begin
        w_req_n   = 1'b1;
        w_we_n    = 1'b1;
        w_addr_n  = FLAG_ADDR;
        w_wdata_n = w_flag_word;
      end
      default: begin
        w_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state       <= IDLE;
      r_idx         <= 9'd0;
      r_back_sel    <= 1'b0;
      r_first_frame <= 1'b1;
      r_dist        <= 16'd0;
      r_tex         <= 16'd0;
      r_poll_cnt    <= '0;
      r_col_ready   <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 16'd0;
      r_mem_wdata   <= 16'd0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dist <= col_distance;
        r_tex  <= col_texture;
      end
      if ((r_state == WR_TEX) && mem_gnt && !w_last) begin
        r_idx <= r_idx + 9'd1;
      end
      if ((r_state == WR_FLAG) && mem_gnt) begin
        r_idx         <= 9'd0;
        r_back_sel    <= ~r_back_sel;
        r_first_frame <= 1'b0;
      end
      r_poll_cnt   <= (r_state == POLL_WAIT) ? r_poll_cnt + 1'b1 : '0;
      r_col_ready  <= (w_next == IDLE);
      r_mem_req    <= w_req_n;
      r_mem_we     <= w_we_n;
      r_mem_addr   <= w_addr_n;
      r_mem_wdata  <= w_wdata_n;
      r_frame_done <= (r_state == WR_FLAG) && mem_gnt;
    end
  end

  assign col_ready  = r_col_ready;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign back_sel   = r_back_sel;
  assign frame_done = r_frame_done;

`ifdef COLUMN_FRAME_WRITER_PERF_EN
  logic w_in_poll;

  assign w_in_poll = (r_state == RD_FLAG) || (r_state == CHK_FLAG) || (r_state == POLL_WAIT);

  sat_counter16 u_frames_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (r_frame_done),
    .count (frames_published)
  );

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (w_in_poll),
    .count (poll_stall_cycles)
  );
`endif

endmodule
`default_nettype wire
